// File: rtl/prod_accum_pkg.sv
// prod_accum shared types and defaults.
// FSM encoding plus default widths.
package prod_accum_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/prod_accum_sat_adder.sv
// Combinational saturating adder: ACC_W-bit
// accumulator plus a zero-extended 16-bit product.
module sat_adder
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [15:0]      b,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  logic [ACC_W:0] w_full;

  assign w_full = {1'b0, a}
                + {{(ACC_W+1-16){1'b0}}, b};
  assign sat    = w_full[ACC_W];
  assign sum    = sat ? '1 : w_full[ACC_W-1:0];

endmodule

// File: rtl/prod_accum.sv
// Accumulates len products with saturation and
// hands the sum downstream over a valid/ready pair.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             p_valid,
  input  logic [15:0]      p,
  output logic             p_ready,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             busy
);

  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_p_ready;
  logic             r_acc_valid;
  logic             r_busy;
  logic [ACC_W-1:0] w_sum;
  logic             w_sat;

  sat_adder #(.ACC_W(ACC_W)) u_add (
    .a   (r_acc),
    .b   (p),
    .sum (w_sum),
    .sat (w_sat)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_p_ready   <= 1'b0;
      r_acc_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= len;
            r_busy <= 1'b1;
            if (len != '0) begin
              r_state   <= ACCUM;
              r_p_ready <= 1'b1;
            end else begin
              r_state     <= DONE;
              r_acc_valid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (p_valid) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_sat;
            r_cnt <= r_cnt - LEN_W'(1);
            if (r_cnt == LEN_W'(1)) begin
              r_state     <= DONE;
              r_p_ready   <= 1'b0;
              r_acc_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (acc_ready) begin
            r_state     <= IDLE;
            r_acc_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_p_ready   <= 1'b0;
          r_acc_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign p_ready   = r_p_ready;
  assign acc_valid = r_acc_valid;
  assign acc       = r_acc;
  assign ovf       = r_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: table runs,
// scoreboarded results and hand-written corner cases.
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start, p_valid, acc_ready;
  logic [3:0]  len;
  logic [15:0] p;
  logic        p_ready, acc_valid, ovf, busy;
  logic [23:0] acc;

  logic        b_start, b_pv, b_ar;
  logic [3:0]  b_len;
  logic [15:0] b_p;
  logic        b_pr, b_av, b_ovf, b_busy;
  logic [15:0] b_acc;

  always #5 clk = ~clk;

  prod_accum u0 (
    .clk(clk), .rstN(rstN), .start(start),
    .len(len), .p_valid(p_valid), .p(p),
    .p_ready(p_ready), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .acc(acc),
    .ovf(ovf), .busy(busy)
  );

  prod_accum #(.ACC_W(16), .LEN_W(4)) u1 (
    .clk(clk), .rstN(rstN), .start(b_start),
    .len(b_len), .p_valid(b_pv), .p(b_p),
    .p_ready(b_pr), .acc_valid(b_av),
    .acc_ready(b_ar), .acc(b_acc),
    .ovf(b_ovf), .busy(b_busy)
  );

  typedef struct packed {
    logic [23:0] acc;
    logic        ovf;
  } exp_t;

  typedef struct {
    int len;
    int pbase;
    int gap_at;
    int gap_n;
    int hold;
    int exp;
  } vec_t;

  exp_t sbq[$];
  int   plist[$];
  vec_t vt[6];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  // Scoreboard pops at every completed result handshake.
  always begin
    @(negedge clk);
    #3;
    if (rstN && acc_valid && acc_ready) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL sb_extra: got acc %0d expected none",
                 acc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_acc", 32'(acc), 32'(e.acc));
        chk("sb_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    logic [23:0] a;
    @(negedge clk);
    start = 1'b1;
    len   = 4'(v.len);
    sbq.push_back('{acc: 24'(v.exp), ovf: 1'b0});
    @(negedge clk);
    start = 1'b0;
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_clr", 32'(acc), 32'd0);
    chk("run_prdy", 32'(p_ready), 32'(v.len != 0));
    for (int i = 0; i < v.len; i++) begin
      if (i == v.gap_at) begin
        p_valid = 1'b0;
        a = acc;
        repeat (v.gap_n) @(negedge clk);
        chk("gap_hold", 32'(acc), 32'(a));
      end
      p_valid = 1'b1;
      p       = 16'(plist[v.pbase + i]);
      @(negedge clk);
    end
    p_valid = 1'b0;
    chk("done_valid", 32'(acc_valid), 32'd1);
    chk("done_prdy", 32'(p_ready), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      chk("hold_acc", 32'(acc), 32'(v.exp));
      chk("hold_valid", 32'(acc_valid), 32'd1);
      @(negedge clk);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(acc_valid), 32'd0);
    chk("idle_acc", 32'(acc), 32'(v.exp));
  endtask

  initial begin
    plist = '{100, 200, 300, 2, 3, 7,
              65535, 65535, 65535, 65535, 65535,
              1, 2, 3, 4, 5, 6, 7, 8};
    vt[0] = '{3, 0, -1, 0, 0, 600};
    vt[1] = '{2, 3, 1, 2, 3, 5};
    vt[2] = '{0, 0, -1, 0, 1, 0};
    vt[3] = '{1, 5, -1, 0, 0, 7};
    vt[4] = '{5, 6, -1, 0, 0, 327675};
    vt[5] = '{8, 11, 4, 1, 2, 36};

    rstN = 1'b0;
    start = 0; len = 0; p_valid = 0; p = 0;
    acc_ready = 0;
    b_start = 0; b_len = 0; b_pv = 0; b_p = 0;
    b_ar = 0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_prdy", 32'(p_ready), 32'd0);
    chk("rst_valid", 32'(acc_valid), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(vt[k]);

    // Start during ACCUM, then start during handshake.
    @(negedge clk);
    start = 1'b1; len = 4'd2;
    sbq.push_back('{acc: 24'd30, ovf: 1'b0});
    @(negedge clk);
    start = 1'b0; p_valid = 1'b1; p = 16'd10;
    @(negedge clk);
    start = 1'b1; len = 4'd9; p = 16'd20;
    @(negedge clk);
    start = 1'b0; p_valid = 1'b0;
    chk("ign_valid", 32'(acc_valid), 32'd1);
    chk("ign_acc", 32'(acc), 32'd30);
    acc_ready = 1'b1; start = 1'b1; len = 4'd1;
    @(negedge clk);
    acc_ready = 1'b0; start = 1'b0;
    chk("hs_start_busy", 32'(busy), 32'd0);
    chk("hs_start_prdy", 32'(p_ready), 32'd0);
    @(negedge clk);
    chk("hs_start_idle", 32'(busy), 32'd0);

    // Reset mid-run drops the partial sum.
    start = 1'b1; len = 4'd4;
    @(negedge clk);
    start = 1'b0; p_valid = 1'b1; p = 16'd50;
    @(negedge clk);
    p_valid = 1'b0;
    chk("pre_rst_acc", 32'(acc), 32'd50);
    #2 rstN = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_prdy", 32'(p_ready), 32'd0);
    chk("arst_acc", 32'(acc), 32'd0);
    chk("arst_valid", 32'(acc_valid), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    run_vec(vt[3]);

    // Saturation on a 16-bit accumulator.
    @(negedge clk);
    b_start = 1'b1; b_len = 4'd2;
    @(negedge clk);
    b_start = 1'b0; b_pv = 1'b1; b_p = 16'd65025;
    @(negedge clk);
    @(negedge clk);
    b_pv = 1'b0;
    chk("sat_valid", 32'(b_av), 32'd1);
    chk("sat_acc", 32'(b_acc), 32'd65535);
    chk("sat_ovf", 32'(b_ovf), 32'd1);
    b_ar = 1'b1;
    @(negedge clk);
    b_ar = 1'b0;
    chk("sat_idle_ovf", 32'(b_ovf), 32'd1);
    chk("sat_idle_acc", 32'(b_acc), 32'd65535);
    b_start = 1'b1; b_len = 4'd1;
    @(negedge clk);
    b_start = 1'b0; b_pv = 1'b1; b_p = 16'd1;
    chk("sat_clr_ovf", 32'(b_ovf), 32'd0);
    @(negedge clk);
    b_pv = 1'b0;
    chk("sat2_acc", 32'(b_acc), 32'd1);
    chk("sat2_ovf", 32'(b_ovf), 32'd0);
    b_ar = 1'b1;
    @(negedge clk);
    b_ar = 1'b0;
    chk("sat2_busy", 32'(b_busy), 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter ACC_W, default 24: accumulator width in bits; legal range 16..32.
REQ-002 Parameter LEN_W, default 4: width of the term-count input.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rstN  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of products to sum; sampled with start.
REQ-007 p_valid  input  1  upstream product valid.
REQ-008 p  input  16  unsigned product from the registered 8x8 multiplier.
REQ-009 p_ready  output  1  block accepts p this cycle.
REQ-010 acc_valid  output  1  accumulated result available.
REQ-011 acc_ready  input  1  downstream consumes the result.
REQ-012 acc  output  ACC_W  accumulated sum, unsigned.
REQ-013 ovf  output  1  sticky saturation flag for the current result.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-016 IDLE: start=1 with len!=0 -> ACCUM; acc cleared to 0, ovf cleared, term counter loaded with len.
REQ-017 IDLE: start=1 with len==0 -> DONE; acc=0, ovf=0.
REQ-018 p_ready SHALL be 1 only in ACCUM; a transfer occurs when p_valid and p_ready are both 1.
REQ-019 On each transfer: acc <= acc + zero-extended p; counter decrements by 1; throughput is one product per cycle.
REQ-020 Addition SHALL be computed at ACC_W+1 bits; on carry-out, acc <= all ones and ovf <= 1.
REQ-021 Once ovf is set, it SHALL stay 1, and acc SHALL stay all ones until the result is consumed.
REQ-022 A transfer with counter==1 SHALL move the FSM to DONE; acc_valid SHALL be 1 in the next cycle, one cycle after the last transfer.
REQ-023 Cycles in ACCUM with p_valid=0 SHALL leave acc, ovf and the counter unchanged.
REQ-024 DONE: acc_valid=1; acc and ovf SHALL be held stable while acc_ready=0.
REQ-025 DONE with acc_ready=1 -> IDLE in the next cycle; acc and ovf SHALL retain their values in IDLE.
REQ-026 start asserted in ACCUM or DONE SHALL be ignored, with no effect on the counter, acc or the FSM.
REQ-027 A start in the same cycle as the DONE->IDLE handshake SHALL be ignored; a new start is accepted from IDLE only.

Reset
REQ-028 rstN=0 SHALL immediately force the FSM to IDLE and set acc=0, ovf=0, counter=0, acc_valid=0, p_ready=0 and busy=0.
REQ-029 Reset during ACCUM or DONE SHALL abandon the partial sum; no result is emitted.

Structure
REQ-030 Package prod_accum_pkg SHALL hold the FSM state enum typedef and the default ACC_W and LEN_W constants.
REQ-031 Saturating addition SHALL live in one sub-module, sat_adder (ACC_W-bit a, 16-bit b, ACC_W-bit sum, sat flag), which is purely combinational.
REQ-032 All registers SHALL reside in prod_accum.

Verification
REQ-033 len=3; p=100, 200, 300 on consecutive cycles -> acc=600, ovf=0, acc_valid high one cycle after the third transfer.
REQ-034 len=2; p=2, idle 2 cycles, p=3; acc_ready low for 3 cycles -> acc=5 held stable, acc_valid high until acc_ready=1, then IDLE.
REQ-035 ACC_W=16, len=2, p=65025 twice -> acc=65535, ovf=1.
REQ-036 start with len=0 -> acc_valid=1 the next cycle, acc=0, p_ready never 1.
REQ-037 len=4; rstN pulsed low after the first transfer -> all outputs 0 asynchronously, FSM in IDLE; a following len=1, p=7 run yields acc=7.
REQ-038 start pulsed (len=9) during ACCUM of a len=2 run -> run completes after 2 transfers with the correct sum.
